ddram_rom_loader: RTL and testbench

- Upstream feeder for the 8-bit DDRAM bridge's word-write port.
- Accepts 16-bit ROM download words from the HPS downloader and optionally drops a 512-byte copier header.
- Buffers words in a small FIFO and issues one toggle-handshake 16-bit write per word, with `wraddr` = `BASE + offset`.
- Throttles the downloader with `ioctl_wait`, and reports completion and the written byte count for the ROM mapper.

---
 rtl/ddram_rom_loader.sv | 200 ++++++++++++++++++++
 tb/tb_ddram_rom_loader.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_rom_loader.sv
// ddram_rom_loader: takes 16-bit words from the HPS ROM downloader, optionally
// drops a copier header, buffers them in a small FIFO and writes each one to
// the DDRAM bridge with a toggle request/acknowledge handshake.
//
// Ports:
//   DDRAM_CLK       clock for all logic
//   reset           synchronous, active-high
//   ioctl_download  high for the whole download
//   ioctl_wr        one-cycle word strobe
//   ioctl_addr      even byte address of the word
//   ioctl_dout      word data, low byte at the even address
//   hdr_skip        drop the leading HDR_BYTES (sampled at download start)
//   ioctl_wait      downloader stall request (registered)
//   wraddr, din     write address/data to the bridge, stable while a request is open
//   we              byte-write strobe, always 0 (word writes only)
//   we_req, we_ack  toggle request / acknowledge
//   rom_size        bytes written excluding the header, valid with done
//   done            one-cycle end-of-load pulse
//   busy            high from download start until done
module ddram_rom_loader #(
    parameter logic [27:0] BASE       = 28'h0000000,
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned HDR_BYTES  = 512
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [27:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    input  logic        hdr_skip,
    output logic        ioctl_wait,
    output logic [27:0] wraddr,
    output logic [15:0] din,
    output logic        we,
    output logic        we_req,
    input  logic        we_ack,
    output logic [27:0] rom_size,
    output logic        done,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [27:0] HDR   = 28'(HDR_BYTES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_dl_prev;
    logic                  r_skip;
    logic                  r_ovf;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_wait;
    logic                  r_we_req;
    logic [27:0]           r_wraddr;
    logic [15:0]           r_din;
    logic [27:0]           r_rom_size;
    logic [27:0]           r_fifo_addr [DEPTH];
    logic [15:0]           r_fifo_data [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wp;
    logic [DEPTH_LOG2-1:0] r_rp;
    logic [CW-1:0]         r_count;

    logic                  w_dl_rise;
    logic                  w_skip_eff;
    logic                  w_in_hdr;
    logic                  w_accept;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_end;
    logic [27:0]           w_offset;
    logic [27:0]           w_sum;
    logic [27:0]           w_push_addr;
    logic [27:0]           w_size_cand;
    logic [27:0]           w_size_base;
    logic [CW-1:0]         w_count_nxt;

    // Input acceptance, header filtering and address arithmetic.
    // A strobe in the same cycle as the download edge uses the live hdr_skip.
    always_comb begin
        w_dl_rise   = ioctl_download & ~r_dl_prev;
        w_skip_eff  = w_dl_rise ? hdr_skip : r_skip;
        w_in_hdr    = w_skip_eff & (ioctl_addr < HDR);
        w_accept    = ioctl_wr & ioctl_download & ~w_in_hdr;
        w_full      = (r_count == CW'(DEPTH));
        w_empty     = (r_count == '0);
        w_push      = w_accept & ~w_full;
        w_offset    = ioctl_addr - (w_skip_eff ? HDR : 28'd0);
        w_sum       = BASE + w_offset;
        w_push_addr = {w_sum[27:1], 1'b0};
        w_size_cand = w_offset + 28'd2;
        // A new download restarts the byte count from zero.
        w_size_base = w_dl_rise ? 28'd0 : r_rom_size;
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        w_end       = ~ioctl_download & w_empty & (r_state == S_IDLE)
                      & (r_we_req == we_ack) & r_busy;
    end

    // Drain FSM: issue one request per word, wait for its acknowledge.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && (r_we_req == we_ack)) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (we_ack == r_we_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; pointers and occupancy live in the control block.
    always_ff @(posedge DDRAM_CLK) begin
        if (w_push) begin
            r_fifo_addr[r_wp] <= w_push_addr;
            r_fifo_data[r_wp] <= ioctl_dout;
        end
    end

    // Control, FIFO pointers, bridge request and status registers.
    // On reset the request is realigned to the bridge's ack, abandoning any
    // open request, since the bridge keeps its ack across our reset.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            r_dl_prev  <= 1'b0;
            r_skip     <= 1'b0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wait     <= 1'b0;
            r_we_req   <= we_ack;
            r_wraddr   <= '0;
            r_din      <= '0;
            r_rom_size <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
        end else begin
            r_dl_prev <= ioctl_download;
            if (w_dl_rise) begin
                r_skip <= hdr_skip;
            end
            r_ovf <= r_ovf | (w_accept & w_full);
            if (w_push) begin
                r_wp <= r_wp + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rp     <= r_rp + DEPTH_LOG2'(1);
                r_wraddr <= r_fifo_addr[r_rp];
                r_din    <= r_fifo_data[r_rp];
                r_we_req <= ~r_we_req;
            end
            r_count <= w_count_nxt;
            // Stall one entry early so a strobe already in flight still fits.
            r_wait  <= (w_count_nxt >= CW'(DEPTH - 1));
            if (w_dl_rise) begin
                r_busy <= 1'b1;
            end else if (w_end) begin
                r_busy <= 1'b0;
            end
            r_done     <= w_end;
            r_rom_size <= (w_push && (w_size_cand > w_size_base)) ? w_size_cand : w_size_base;
        end
    end

    assign ioctl_wait = r_wait;
    assign wraddr     = r_wraddr;
    assign din        = r_din;
    assign we         = 1'b0;
    assign we_req     = r_we_req;
    assign rom_size   = r_rom_size;
    assign done       = r_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ddram_rom_loader.sv
// Testbench for ddram_rom_loader: directed download scenarios against a
// behavioural DDRAM bridge that acknowledges toggles after a set delay.
module tb_ddram_rom_loader;

    localparam logic [27:0] BASE = 28'h0100000;

    logic        clk;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [27:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        hdr_skip;
    logic        ioctl_wait;
    logic [27:0] wraddr;
    logic [15:0] din;
    logic        we;
    logic        we_req;
    logic        we_ack;
    logic [27:0] rom_size;
    logic        done;
    logic        busy;

    int n_checks;
    int n_fail;

    // Bridge model state.
    int          ack_delay;
    bit          ack_hold;
    int          toggles;
    int          done_cnt;
    int          done_toggles;
    bit          done_pending;
    int          stab_err;
    int          cyc;
    bit          pending;
    int          wait_cnt;
    logic        last_req;
    logic [27:0] cur_a;
    logic [15:0] cur_d;
    logic [27:0] log_addr [$];
    logic [15:0] log_data [$];
    int          log_cyc  [$];

    ddram_rom_loader #(
        .BASE      (BASE),
        .DEPTH_LOG2(2),
        .HDR_BYTES (512)
    ) dut (
        .DDRAM_CLK     (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .hdr_skip      (hdr_skip),
        .ioctl_wait    (ioctl_wait),
        .wraddr        (wraddr),
        .din           (din),
        .we            (we),
        .we_req        (we_req),
        .we_ack        (we_ack),
        .rom_size      (rom_size),
        .done          (done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bridge: logs each request toggle, checks address/data hold, acks after ack_delay.
    initial begin
        we_ack   = 1'b0;
        pending  = 1'b0;
        toggles  = 0;
        done_cnt = 0;
        stab_err = 0;
        cyc      = 0;
        last_req = 1'b0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                done_toggles = toggles;
                done_pending = pending;
            end
            if (reset === 1'b1) begin
                pending  = 1'b0;
                last_req = we_req;
            end else begin
                if (we_req !== last_req) begin
                    toggles++;
                    log_addr.push_back(wraddr);
                    log_data.push_back(din);
                    log_cyc.push_back(cyc);
                    last_req = we_req;
                    cur_a    = wraddr;
                    cur_d    = din;
                    pending  = 1'b1;
                    wait_cnt = ack_delay;
                end else if (pending && (wraddr !== cur_a || din !== cur_d)) begin
                    stab_err++;
                end
                if (pending && !ack_hold) begin
                    if (wait_cnt <= 1) begin
                        we_ack  = we_req;
                        pending = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    // Downloader: word i at a0+2i carrying 16'h1111*(i+1); honours ioctl_wait.
    task automatic do_download(input bit skip, input int nwords, input logic [27:0] a0);
        int guard;
        @(negedge clk);
        hdr_skip       = skip;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            ioctl_wr = 1'b0;
            guard    = 0;
            while (ioctl_wait === 1'b1 && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL dl_wait_timeout: ioctl_wait stuck at %b, need 0", ioctl_wait);
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 28'(a0 + 28'(2 * i));
            ioctl_dout = 16'(16'h1111 * (i + 1));
        end
        @(negedge clk);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int guard;
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: done count %0d, need %0d", done_cnt, d0 + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ioctl_wait, done, busy, we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_flags: wait/done/busy/we %b, need 0000", {ioctl_wait, done, busy, we});
        end
        n_checks++;
        if (wraddr !== 28'd0 || din !== 16'd0 || rom_size !== 28'd0) begin
            n_fail++;
            $display("FAIL rst_data: wraddr %h din %h rom_size %h, need 0", wraddr, din, rom_size);
        end
        n_checks++;
        if (we_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req: we_req %b, need 0", we_req);
        end
        n_checks++;
        if (dut.r_count !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_fifo: count %0d, need 0", dut.r_count);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int t0, d0, lb;
        t0 = toggles; d0 = done_cnt; lb = log_addr.size();
        ack_delay = 3;
        do_download(1'b0, 3, 28'd0);
        wait_done(d0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (toggles - t0 !== 3) begin
            n_fail++;
            $display("FAIL basic_toggles: %0d, need 3", toggles - t0);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (log_addr[lb + i] !== 28'(BASE + 28'(2 * i)) || log_data[lb + i] !== 16'(16'h1111 * (i + 1))) begin
                n_fail++;
                $display("FAIL basic_wr%0d: addr %h data %h, need %h %h", i, log_addr[lb + i],
                         log_data[lb + i], 28'(BASE + 28'(2 * i)), 16'(16'h1111 * (i + 1)));
            end
        end
        n_checks++;
        if (rom_size !== 28'd6) begin
            n_fail++;
            $display("FAIL basic_size: rom_size %0d, need 6", rom_size);
        end
        n_checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: pulses %0d busy %b, need 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_header();
        int t0, d0, lb;
        t0 = toggles; d0 = done_cnt; lb = log_addr.size();
        do_download(1'b1, 258, 28'd0);
        wait_done(d0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (toggles - t0 !== 2) begin
            n_fail++;
            $display("FAIL hdr_toggles: %0d, need 2", toggles - t0);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (log_addr[lb + i] !== 28'(BASE + 28'(2 * i)) || log_data[lb + i] !== 16'(16'h1111 * (257 + i))) begin
                n_fail++;
                $display("FAIL hdr_wr%0d: addr %h data %h, need %h %h", i, log_addr[lb + i],
                         log_data[lb + i], 28'(BASE + 28'(2 * i)), 16'(16'h1111 * (257 + i)));
            end
        end
        n_checks++;
        if (rom_size !== 28'd4) begin
            n_fail++;
            $display("FAIL hdr_size: rom_size %0d, need 4", rom_size);
        end
    endtask

    task automatic test_backpressure();
        int t0, d0, lb;
        t0 = toggles; d0 = done_cnt; lb = log_addr.size();
        ack_hold = 1'b1;
        fork
            do_download(1'b0, 8, 28'd0);
            begin
                int g;
                g = 0;
                while (ioctl_wait !== 1'b1 && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                n_checks++;
                if (ioctl_wait !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_wait: ioctl_wait %b, need 1", ioctl_wait);
                end
                n_checks++;
                if (dut.r_count !== 3'd3) begin
                    n_fail++;
                    $display("FAIL bp_occ: count %0d at wait rise, need 3", dut.r_count);
                end
                repeat (50) @(negedge clk);
                ack_hold = 1'b0;
            end
        join
        wait_done(d0);
        repeat (5) @(negedge clk);
        n_checks++;
        if (dut.r_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf: ovf %b, need 0", dut.r_ovf);
        end
        n_checks++;
        if (toggles - t0 !== 8) begin
            n_fail++;
            $display("FAIL bp_toggles: %0d, need 8", toggles - t0);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (log_addr[lb + i] !== 28'(BASE + 28'(2 * i)) || log_data[lb + i] !== 16'(16'h1111 * (i + 1))) begin
                n_fail++;
                $display("FAIL bp_wr%0d: addr %h data %h, need %h %h", i, log_addr[lb + i],
                         log_data[lb + i], 28'(BASE + 28'(2 * i)), 16'(16'h1111 * (i + 1)));
            end
        end
        n_checks++;
        if (rom_size !== 28'd16) begin
            n_fail++;
            $display("FAIL bp_size: rom_size %0d, need 16", rom_size);
        end
    endtask

    task automatic test_fast_ack();
        int t0, d0, lb;
        t0 = toggles; d0 = done_cnt; lb = log_addr.size();
        ack_delay = 1;
        do_download(1'b0, 8, 28'd0);
        wait_done(d0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (toggles - t0 !== 8) begin
            n_fail++;
            $display("FAIL fast_toggles: %0d, need 8", toggles - t0);
        end
        for (int i = 1; i < 8; i++) begin
            n_checks++;
            if (log_cyc[lb + i] - log_cyc[lb + i - 1] !== 2) begin
                n_fail++;
                $display("FAIL fast_gap%0d: %0d cycles, need 2", i, log_cyc[lb + i] - log_cyc[lb + i - 1]);
            end
        end
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL fast_done_cnt: %0d pulses, need 1", done_cnt - d0);
        end
        n_checks++;
        if (done_toggles - t0 !== 8 || done_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_done_order: toggles at done %0d pending %b, need 8 0",
                     done_toggles - t0, done_pending);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d changes while open, need 0", stab_err);
        end
        ack_delay = 3;
    endtask

    task automatic test_empty();
        int t0, d0;
        logic req0;
        t0 = toggles; d0 = done_cnt; req0 = we_req;
        @(negedge clk);
        ioctl_download = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_busy: busy %b, need 1", busy);
        end
        ioctl_download = 1'b0;
        wait_done(d0);
        repeat (10) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_fail++;
            $display("FAIL empty_done: %0d pulses, need 1", done_cnt - d0);
        end
        n_checks++;
        if (rom_size !== 28'd0) begin
            n_fail++;
            $display("FAIL empty_size: rom_size %0d, need 0", rom_size);
        end
        n_checks++;
        if (toggles !== t0 || we_req !== req0) begin
            n_fail++;
            $display("FAIL empty_req: toggles %0d we_req %b, need %0d %b", toggles - t0, we_req, 0, req0);
        end
    endtask

    task automatic test_reset_mid();
        int t0, d0;
        ack_hold = 1'b1;
        n_checks++;
        if (we_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: we_req %b, need 1", we_req);
        end
        do_download(1'b0, 3, 28'd0);
        n_checks++;
        if (we_req !== 1'b0 || we_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inflight: we_req %b we_ack %b, need 0 1", we_req, we_ack);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (we_req !== 1'b1 || busy !== 1'b0 || ioctl_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst: we_req %b busy %b wait %b, need 1 0 0", we_req, busy, ioctl_wait);
        end
        n_checks++;
        if (dut.r_count !== 3'd0 || wraddr !== 28'd0 || din !== 16'd0 || rom_size !== 28'd0) begin
            n_fail++;
            $display("FAIL mid_rst_data: count %0d wraddr %h din %h size %h, need 0", dut.r_count, wraddr, din, rom_size);
        end
        @(negedge clk);
        reset    = 1'b0;
        ack_hold = 1'b0;
        t0 = toggles; d0 = done_cnt;
        repeat (20) @(negedge clk);
        n_checks++;
        if (toggles !== t0 || we_req !== 1'b1 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL mid_quiet: toggles %0d we_req %b dones %0d, need 0 1 0", toggles - t0, we_req, done_cnt - d0);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        ack_delay      = 3;
        ack_hold       = 1'b0;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        hdr_skip       = 1'b0;
        test_reset();
        test_basic();
        test_header();
        test_backpressure();
        test_fast_ack();
        test_empty();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
